alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter DEPTH, default 4: number of reservation-station entries.
REQ-002 Parameter TAG_W, default 6: physical-tag width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 disp_valid  in  1  dispatch request.
REQ-006 disp_ready  out  1  entry available.
REQ-007 disp_ctrl  in  4  ALU control code.
REQ-008 disp_alusrc  in  1  1 = second operand is the immediate.
REQ-009 disp_imm  in  32  immediate.
REQ-010 disp_rs1_val / disp_rs2_val  in  32 each  operand values, meaningful when the matching _rdy is 1.
REQ-011 disp_rs1_rdy / disp_rs2_rdy  in  1 each  operand already available.
REQ-012 disp_rs1_tag / disp_rs2_tag  in  TAG_W each  producer tags.
REQ-013 disp_dest_tag  in  TAG_W  result tag.
REQ-014 cdb_valid / cdb_tag / cdb_value  in  1 / TAG_W / 32  common-data-bus broadcast.
REQ-015 flush  in  1  synchronous squash of all entries.
REQ-016 iss_valid  out  1  issue request to the ALU.
REQ-017 iss_ready  in  1  ALU accepts the issue.
REQ-018 iss_rs1 / iss_rs2 / iss_imm  out  32 each  operands to the ALU.
REQ-019 iss_alu_ctrl / iss_alusrc / iss_dest_tag  out  4 / 1 / TAG_W  control and tag to the ALU.
REQ-020 occupancy  out  clog2(DEPTH)+1  count of valid entries.
REQ-021 illegal_op  out  1  one-cycle pulse on an accepted dispatch with an unsupported disp_ctrl.

Function
REQ-022 Dispatch SHALL occur when disp_valid && disp_ready && !flush; the entry SHALL be written at that clock edge.
REQ-023 disp_ready SHALL be 1 exactly when occupancy < DEPTH; a same-cycle issue SHALL NOT raise disp_ready.
REQ-024 Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 1110 SRA.
REQ-025 Any other disp_ctrl SHALL still be accepted and SHALL pulse illegal_op in the following cycle.
REQ-026 When disp_alusrc=1, rs2 SHALL be stored as ready with value 0, and disp_rs2_rdy/disp_rs2_tag SHALL be ignored.
REQ-027 Wakeup: on cdb_valid, every valid entry holding a not-ready operand whose tag equals cdb_tag SHALL capture cdb_value and mark that operand ready.
REQ-028 Dispatch bypass: a dispatched operand with _rdy=0 whose tag equals cdb_tag while cdb_valid=1 SHALL be stored ready with cdb_value.
REQ-029 Issue eligibility SHALL use registered entry state only.
REQ-030 Minimum latency from dispatch (or wakeup) to iss_valid SHALL be 1 cycle.
REQ-031 Selection: iss_valid SHALL be 1 when any valid entry has both operands ready; iss_* SHALL present the oldest such entry by dispatch order.
REQ-032 Hold rule: while iss_valid && !iss_ready, iss_* SHALL remain stable on the same entry, even if an older entry becomes ready.
REQ-033 The issued entry SHALL be freed on the edge where iss_valid && iss_ready.
REQ-034 Simultaneous dispatch and issue SHALL leave occupancy unchanged.
REQ-035 Age order SHALL be preserved across frees and refills; there SHALL be no wrap-around misordering.
REQ-036 Flush SHALL invalidate all entries at the edge: occupancy=0 and iss_valid=0 in the next cycle.
REQ-037 Flush SHALL take priority over a same-cycle dispatch and issue; the ALU handshake in that cycle SHALL be treated as accepted.
REQ-038 When iss_valid=0, iss_* SHALL be driven to 0.

Reset
REQ-039 While rst_n=0, all entries SHALL be invalid, occupancy=0, iss_valid=0, iss_* = 0, illegal_op=0, and disp_ready=1, independent of clk.
REQ-040 Reset asserted mid-operation SHALL discard all entries immediately; the first dispatch SHALL be accepted on the first clock edge after rst_n rises.

Verification
REQ-041 Dispatch ADD with rs1=5 and rs2=7 both ready -> next cycle iss_valid=1, iss_rs1=5, iss_rs2=7, iss_alu_ctrl=0010; with iss_ready=1, occupancy returns to 0.
REQ-042 Dispatch SUB with rs1 tag 3 not ready; CDB broadcasts tag 3 value 0x10 two cycles later -> iss_valid rises the cycle after the broadcast with iss_rs1=0x10.
REQ-043 Fill 4 entries with iss_ready=0 -> disp_ready=0 and occupancy=4; pulse iss_ready for one cycle -> the oldest entry issues and disp_ready=1 on the next cycle.
REQ-044 Hold iss_ready=0 on entry B while older entry A wakes up -> iss_* stays on B until accepted, then A issues.
REQ-045 Dispatch with disp_ctrl=1111 -> illegal_op pulses 1 cycle; flush with 3 entries valid plus a same-cycle dispatch -> occupancy=0 and iss_valid=0 next cycle.
REQ-046 Assert rst_n=0 asynchronously with 2 entries valid -> occupancy=0 and iss_valid=0 before the next clk edge.

Source files
------------

// File: rtl/alu_rs.sv
// ALU reservation station: age-ordered entries with CDB wakeup and
// oldest-ready issue; a stalled issue stays locked on its entry.
module alu_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [3:0]                 disp_ctrl,
  input  logic                       disp_alusrc,
  input  logic [31:0]                disp_imm,
  input  logic [31:0]                disp_rs1_val,
  input  logic [31:0]                disp_rs2_val,
  input  logic                       disp_rs1_rdy,
  input  logic                       disp_rs2_rdy,
  input  logic [TAG_W-1:0]           disp_rs1_tag,
  input  logic [TAG_W-1:0]           disp_rs2_tag,
  input  logic [TAG_W-1:0]           disp_dest_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_value,
  input  logic                       flush,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [31:0]                iss_rs1,
  output logic [31:0]                iss_rs2,
  output logic [31:0]                iss_imm,
  output logic [3:0]                 iss_alu_ctrl,
  output logic                       iss_alusrc,
  output logic [TAG_W-1:0]           iss_dest_tag,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       illegal_op
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [3:0]       ctrl;
    logic             alusrc;
    logic [31:0]      imm;
    logic [31:0]      v1;
    logic             r1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      v2;
    logic             r2;
    logic [TAG_W-1:0] t2;
    logic [TAG_W-1:0] dest;
  } ent_t;

  // Slot 0 is always the oldest entry; frees compact the array.
  ent_t          q  [DEPTH];
  ent_t          w  [DEPTH];
  ent_t          nq [DEPTH];
  ent_t          nd;
  ent_t          cur;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ncnt;
  logic [CW-1:0] wp;
  logic          lock;
  logic [IW-1:0] lock_idx;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] sel;
  logic          legal;
  logic          do_disp;
  logic          do_iss;

  always_comb begin
    legal = 1'b0;
    unique case (disp_ctrl)
      4'b0000, 4'b0001, 4'b0010,
      4'b0110, 4'b0011, 4'b1110: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i < int'(cnt) && q[i].r1 && q[i].r2) begin
        found = 1'b1;
        pick  = IW'(i);
      end
    end
  end

  assign sel        = lock ? lock_idx : pick;
  assign cur        = q[sel];
  assign iss_valid  = lock | found;
  assign disp_ready = (cnt < CW'(DEPTH));
  assign occupancy  = cnt;
  assign do_disp    = disp_valid && disp_ready && !flush;
  assign do_iss     = iss_valid && iss_ready && !flush;

  always_comb begin
    iss_rs1      = '0;
    iss_rs2      = '0;
    iss_imm      = '0;
    iss_alu_ctrl = '0;
    iss_alusrc   = 1'b0;
    iss_dest_tag = '0;
    if (iss_valid) begin
      iss_rs1      = cur.v1;
      iss_rs2      = cur.v2;
      iss_imm      = cur.imm;
      iss_alu_ctrl = cur.ctrl;
      iss_alusrc   = cur.alusrc;
      iss_dest_tag = cur.dest;
    end
  end

  always_comb begin
    nd        = '0;
    nd.ctrl   = disp_ctrl;
    nd.alusrc = disp_alusrc;
    nd.imm    = disp_imm;
    nd.dest   = disp_dest_tag;
    nd.t1     = disp_rs1_tag;
    nd.r1     = disp_rs1_rdy || (cdb_valid && disp_rs1_tag == cdb_tag);
    nd.v1     = disp_rs1_rdy ? disp_rs1_val : cdb_value;
    if (disp_alusrc) begin
      nd.r2 = 1'b1;
      nd.v2 = '0;
      nd.t2 = '0;
    end else begin
      nd.t2 = disp_rs2_tag;
      nd.r2 = disp_rs2_rdy || (cdb_valid && disp_rs2_tag == cdb_tag);
      nd.v2 = disp_rs2_rdy ? disp_rs2_val : cdb_value;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = q[i];
      if (cdb_valid && !w[i].r1 && w[i].t1 == cdb_tag) begin
        w[i].r1 = 1'b1;
        w[i].v1 = cdb_value;
      end
      if (cdb_valid && !w[i].r2 && w[i].t2 == cdb_tag) begin
        w[i].r2 = 1'b1;
        w[i].v2 = cdb_value;
      end
    end
    wp = cnt - CW'(do_iss);
    for (int i = 0; i < DEPTH; i++) begin
      nq[i] = w[i];
      if (do_iss && i >= int'(sel))
        nq[i] = w[(i + 1) % DEPTH];
      if (do_disp && i == int'(wp))
        nq[i] = nd;
    end
    ncnt = cnt + CW'(do_disp) - CW'(do_iss);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      cnt        <= '0;
      lock       <= 1'b0;
      lock_idx   <= '0;
      illegal_op <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nq[i];
      cnt        <= flush ? '0 : ncnt;
      lock       <= iss_valid && !iss_ready && !flush;
      lock_idx   <= sel;
      illegal_op <= do_disp && !legal;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: queue-based reference model checked every cycle,
// directed scenarios followed by randomized traffic.
module tb_alu_rs;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             disp_valid;
  logic             disp_ready;
  logic [3:0]       disp_ctrl;
  logic             disp_alusrc;
  logic [31:0]      disp_imm;
  logic [31:0]      disp_rs1_val;
  logic [31:0]      disp_rs2_val;
  logic             disp_rs1_rdy;
  logic             disp_rs2_rdy;
  logic [TAG_W-1:0] disp_rs1_tag;
  logic [TAG_W-1:0] disp_rs2_tag;
  logic [TAG_W-1:0] disp_dest_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             flush;
  logic             iss_valid;
  logic             iss_ready;
  logic [31:0]      iss_rs1;
  logic [31:0]      iss_rs2;
  logic [31:0]      iss_imm;
  logic [3:0]       iss_alu_ctrl;
  logic             iss_alusrc;
  logic [TAG_W-1:0] iss_dest_tag;
  logic [2:0]       occupancy;
  logic             illegal_op;

  alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_ctrl(disp_ctrl), .disp_alusrc(disp_alusrc),
    .disp_imm(disp_imm),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_dest_tag(disp_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_imm(iss_imm),
    .iss_alu_ctrl(iss_alu_ctrl), .iss_alusrc(iss_alusrc),
    .iss_dest_tag(iss_dest_tag),
    .occupancy(occupancy), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [3:0]  ctrl;
    logic        alusrc;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
    bit          r1;
    bit          r2;
    logic [5:0]  t1;
    logic [5:0]  t2;
    logic [5:0]  dest;
  } ment_t;

  ment_t m[$];
  int    held = -1;
  int    next_id = 0;
  bit    exp_ill = 0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int sel_pos();
    if (held >= 0)
      foreach (m[i]) if (m[i].id == held) return i;
    foreach (m[i]) if (m[i].r1 && m[i].r2) return i;
    return -1;
  endfunction

  function automatic bit is_legal(logic [3:0] c);
    return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b1110};
  endfunction

  task automatic model_reset();
    m.delete();
    held    = -1;
    exp_ill = 0;
  endtask

  task automatic model_edge();
    int    p;
    bit    dsp;
    ment_t e;
    p   = sel_pos();
    dsp = disp_valid && (m.size() < DEPTH) && !flush;
    if (flush) begin
      model_reset();
      return;
    end
    if (cdb_valid)
      foreach (m[i]) begin
        if (!m[i].r1 && m[i].t1 == cdb_tag) begin m[i].r1 = 1; m[i].v1 = cdb_value; end
        if (!m[i].r2 && m[i].t2 == cdb_tag) begin m[i].r2 = 1; m[i].v2 = cdb_value; end
      end
    if (p >= 0 && iss_ready) begin
      m.delete(p);
      held = -1;
    end else if (p >= 0) held = m[p].id;
    else held = -1;
    exp_ill = dsp && !is_legal(disp_ctrl);
    if (dsp) begin
      e.id     = next_id++;
      e.ctrl   = disp_ctrl;
      e.alusrc = disp_alusrc;
      e.imm    = disp_imm;
      e.dest   = disp_dest_tag;
      e.t1     = disp_rs1_tag;
      e.r1     = disp_rs1_rdy || (cdb_valid && disp_rs1_tag == cdb_tag);
      e.v1     = disp_rs1_rdy ? disp_rs1_val : cdb_value;
      if (disp_alusrc) begin
        e.t2 = '0; e.r2 = 1; e.v2 = '0;
      end else begin
        e.t2 = disp_rs2_tag;
        e.r2 = disp_rs2_rdy || (cdb_valid && disp_rs2_tag == cdb_tag);
        e.v2 = disp_rs2_rdy ? disp_rs2_val : cdb_value;
      end
      m.push_back(e);
    end
  endtask

  task automatic check_all();
    int p;
    p = sel_pos();
    chk("occupancy", 32'(occupancy), m.size());
    chk("disp_ready", 32'(disp_ready), 32'(m.size() < DEPTH));
    chk("iss_valid", 32'(iss_valid), 32'(p >= 0));
    chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
    if (p >= 0) begin
      chk("iss_rs1", iss_rs1, m[p].v1);
      chk("iss_rs2", iss_rs2, m[p].v2);
      chk("iss_imm", iss_imm, m[p].imm);
      chk("iss_ctrl", 32'(iss_alu_ctrl), 32'(m[p].ctrl));
      chk("iss_alusrc", 32'(iss_alusrc), 32'(m[p].alusrc));
      chk("iss_dest", 32'(iss_dest_tag), 32'(m[p].dest));
    end else begin
      chk("iss_zero", {iss_rs1 | iss_rs2 | iss_imm}, 32'd0);
      chk("iss_zero_ctl", {iss_alu_ctrl, iss_alusrc, iss_dest_tag}, 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    disp_valid = 0;
    cdb_valid  = 0;
    flush      = 0;
  endtask

  task automatic disp(logic [3:0] c, logic [31:0] v1, bit r1, logic [5:0] t1,
                      logic [31:0] v2, bit r2, logic [5:0] t2, logic [5:0] d);
    disp_valid    = 1;
    disp_ctrl     = c;
    disp_alusrc   = 0;
    disp_imm      = 32'h100 + 32'(d);
    disp_rs1_val  = v1;
    disp_rs1_rdy  = r1;
    disp_rs1_tag  = t1;
    disp_rs2_val  = v2;
    disp_rs2_rdy  = r2;
    disp_rs2_tag  = t2;
    disp_dest_tag = d;
  endtask

  initial begin
    rst_n = 0;
    iss_ready = 0;
    disp_ctrl = 0; disp_alusrc = 0; disp_imm = 0;
    disp_rs1_val = 0; disp_rs2_val = 0;
    disp_rs1_rdy = 0; disp_rs2_rdy = 0;
    disp_rs1_tag = 0; disp_rs2_tag = 0; disp_dest_tag = 0;
    cdb_tag = 0; cdb_value = 0;
    idle();
    #3;
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_drdy", 32'(disp_ready), 32'd1);
    chk("rst_ivld", 32'(iss_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // ADD with both operands ready
    iss_ready = 1;
    disp(4'b0010, 32'd5, 1, 6'd0, 32'd7, 1, 6'd0, 6'd20);
    step(); idle();
    chk("add_vld", 32'(iss_valid), 32'd1);
    chk("add_rs1", iss_rs1, 32'd5);
    chk("add_rs2", iss_rs2, 32'd7);
    chk("add_ctl", 32'(iss_alu_ctrl), 32'b0010);
    step();
    chk("add_occ", 32'(occupancy), 32'd0);

    // SUB waiting on tag 3
    disp(4'b0110, 32'd0, 0, 6'd3, 32'd1, 1, 6'd0, 6'd21);
    step(); idle();
    step();
    chk("sub_wait", 32'(iss_valid), 32'd0);
    cdb_valid = 1; cdb_tag = 6'd3; cdb_value = 32'h10;
    step(); idle();
    chk("sub_vld", 32'(iss_valid), 32'd1);
    chk("sub_rs1", iss_rs1, 32'h10);
    step();

    // fill, then single accept
    iss_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(4'b0001, 32'(40 + i), 1, 6'd0, 32'd2, 1, 6'd0, 6'(30 + i));
      step();
    end
    idle();
    chk("full_drdy", 32'(disp_ready), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd4);
    iss_ready = 1;
    step();
    iss_ready = 0;
    chk("pop_drdy", 32'(disp_ready), 32'd1);
    chk("pop_next", iss_rs1, 32'd41);
    iss_ready = 1;
    for (int i = 0; i < DEPTH; i++) step();
    chk("drain_occ", 32'(occupancy), 32'd0);

    // hold on younger B while older A wakes
    iss_ready = 0;
    disp(4'b0011, 32'd0, 0, 6'd9, 32'd3, 1, 6'd0, 6'd40);
    step();
    disp(4'b0000, 32'hB, 1, 6'd0, 32'd4, 1, 6'd0, 6'd41);
    step(); idle();
    step();
    cdb_valid = 1; cdb_tag = 6'd9; cdb_value = 32'hA;
    step(); idle();
    step();
    chk("hold_b", iss_rs1, 32'hB);
    iss_ready = 1;
    step();
    chk("then_a", iss_rs1, 32'hA);
    step();

    // illegal code
    disp(4'b1111, 32'd1, 1, 6'd0, 32'd1, 1, 6'd0, 6'd50);
    step(); idle();
    chk("ill_hi", 32'(illegal_op), 32'd1);
    step();
    chk("ill_lo", 32'(illegal_op), 32'd0);

    // flush beats dispatch and issue
    iss_ready = 0;
    for (int i = 0; i < 3; i++) begin
      disp(4'b0010, 32'(i), 1, 6'd0, 32'd1, 1, 6'd0, 6'(51 + i));
      step();
    end
    disp(4'b0010, 32'd9, 1, 6'd0, 32'd1, 1, 6'd0, 6'd60);
    flush = 1; iss_ready = 1;
    step(); idle();
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_vld", 32'(iss_valid), 32'd0);

    // async reset mid-operation
    iss_ready = 0;
    for (int i = 0; i < 2; i++) begin
      disp(4'b0001, 32'(70 + i), 1, 6'd0, 32'd1, 1, 6'd0, 6'(61 + i));
      step();
    end
    idle();
    #2 rst_n = 0;
    #1;
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_vld", 32'(iss_valid), 32'd0);
    chk("arst_drdy", 32'(disp_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    disp(4'b0010, 32'd1, 1, 6'd0, 32'd1, 1, 6'd0, 6'd63);
    step(); idle();
    chk("post_rst_occ", 32'(occupancy), 32'd1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      disp_valid    = ($urandom_range(9) < 6);
      disp_ctrl     = ($urandom_range(15) == 0) ? 4'($urandom) : 4'b0010;
      disp_alusrc   = ($urandom_range(3) == 0);
      disp_imm      = $urandom;
      disp_rs1_val  = $urandom;
      disp_rs2_val  = $urandom;
      disp_rs1_rdy  = ($urandom_range(1) == 0);
      disp_rs2_rdy  = ($urandom_range(1) == 0);
      disp_rs1_tag  = 6'($urandom_range(7));
      disp_rs2_tag  = 6'($urandom_range(7));
      disp_dest_tag = 6'($urandom);
      cdb_valid     = ($urandom_range(9) < 4);
      cdb_tag       = 6'($urandom_range(7));
      cdb_value     = $urandom;
      flush         = ($urandom_range(39) == 0);
      iss_ready     = ($urandom_range(1) == 0);
      step();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
